// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 UART receiver with synchronizer, glitch filter, holding register and error flags
//   clk_48mhz  : system clock, all logic on rising edge
//   reset_n    : asynchronous active-low reset
//   uart_rx_in : raw serial line, idles high, asynchronous to clk_48mhz
//   rx_data    : received byte, valid while rx_valid = 1
//   rx_valid   : holding register full
//   rx_ready   : consumer accepts the byte when rx_valid & rx_ready
//   frame_err  : one-cycle pulse on a bad stop bit
//   overrun    : sticky, a completed byte was dropped because the holding register was full
//   clr_err    : synchronous clear of overrun (a simultaneous set wins)
module uart_rx_frontend #(
    parameter int CLK_FREQ = 48000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       uart_rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(HALF_BIT - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state, state_nx;
    logic          sync1, rx_s;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tmr_clr, shift_en, good, bad;

    always_ff @(posedge clk_48mhz or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = state;
        tmr_clr  = 1'b0;
        shift_en = 1'b0;
        good     = 1'b0;
        bad      = 1'b0;
        case (state)
            IDLE: begin
                tmr_clr = 1'b1;
                if (!rx_s) state_nx = START;
            end
            START:
                if (timer == T_HALF) begin
                    tmr_clr  = 1'b1;
                    state_nx = rx_s ? IDLE : DATA;
                end
            DATA:
                if (timer == T_FULL) begin
                    tmr_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end
            STOP:
                if (timer == T_FULL) begin
                    tmr_clr  = 1'b1;
                    good     = rx_s;
                    bad      = !rx_s;
                    state_nx = rx_s ? IDLE : WAIT_IDLE;
                end
            WAIT_IDLE: begin
                tmr_clr = 1'b1;
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Synchronizer resets to the idle level so a reset never fakes a start edge.
    always_ff @(posedge clk_48mhz or negedge reset_n)
        if (!reset_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            sync1   <= uart_rx_in;
            rx_s    <= sync1;
            timer   <= tmr_clr ? '0 : timer + TW'(1);
            bit_idx <= (state != DATA) ? 3'd0 : shift_en ? bit_idx + 3'd1 : bit_idx;
            shreg   <= shift_en ? {rx_s, shreg[7:1]} : shreg;
        end

    // A byte may load when the register is empty or is being emptied this cycle.
    always_ff @(posedge clk_48mhz or negedge reset_n)
        if (!reset_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad;
            if (good && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            overrun <= (good && rx_valid && !rx_ready) ? 1'b1 : clr_err ? 1'b0 : overrun;
        end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: scoreboard bench for uart_rx_frontend (directed scenarios plus randomized frames)
//   Drives serial frames bit by bit, queues the bytes a correct receiver must hand over,
//   and a negedge monitor checks every handshake against the queue and counts frame_err cycles.
`timescale 1ns/1ps
module tb_uart_rx_frontend;
    localparam int BAUD = 115200;
    localparam int CPB  = 32;
    localparam int CLK_FREQ = BAUD * CPB;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       line = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       clr_err = 1'b0;

    logic [7:0] q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         ferr_cnt = 0;
    int         exp_ferr = 0;

    uart_rx_frontend #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk_48mhz(clk),
        .reset_n(reset_n),
        .uart_rx_in(line),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit; each bit held CPB cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk); #1 line = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 line = b[i];
        end
        repeat (CPB) @(posedge clk); #1 line = stop;
        repeat (CPB) @(posedge clk); #1 line = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        idle(2);
        rx_ready = 1'b0;
    endtask

    always @(negedge clk)
        if (reset_n) begin
            if (frame_err) ferr_cnt++;
            if (rx_valid && rx_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                end else begin
                    check("rx_data_handshake", {24'd0, rx_data}, {24'd0, q.pop_front()});
                end
            end
        end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        int  wait_cnt;
        bit  done;
        logic [7:0] b;
        logic bad;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        reset_n = 1'b1;
        idle(4);

        q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                lat = 0;
                @(posedge clk);
                @(negedge clk);
                while (!rx_valid && lat < 2000) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                end
            end
        join
        n_chk++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, LAT);
        end
        check("hold_55_data", rx_data, 8'h55);
        idle(100);
        check("hold_55_valid", rx_valid, 1);
        check("hold_55_data_late", rx_data, 8'h55);
        accept();
        check("valid_cleared", rx_valid, 0);

        line = 1'b0;
        idle(HALF / 2);
        line = 1'b1;
        idle(3 * CPB);
        check("glitch_no_valid", rx_valid, 0);
        check("glitch_no_ferr", ferr_cnt, exp_ferr);
        q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        check("after_glitch_valid", rx_valid, 1);
        check("after_glitch_data", rx_data, 8'hA3);
        accept();

        send_frame(8'h3C, 1'b0);
        exp_ferr++;
        idle(CPB);
        check("bad_stop_ferr_cycles", ferr_cnt, exp_ferr);
        check("bad_stop_no_valid", rx_valid, 0);
        q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        check("after_ferr_data", rx_data, 8'h81);
        accept();

        q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("overrun_data_kept", rx_data, 8'h11);
        check("overrun_valid", rx_valid, 1);
        check("overrun_set", overrun, 1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check("overrun_cleared", overrun, 0);

        q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (LAT) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        check("same_cycle_data", rx_data, 8'h22);
        check("same_cycle_valid", rx_valid, 1);
        check("same_cycle_no_overrun", overrun, 0);
        accept();

        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * CPB + CPB / 2) @(posedge clk);
                #1 reset_n = 1'b0;
                idle(3);
                check("midreset_valid", rx_valid, 0);
                check("midreset_data", rx_data, 0);
                check("midreset_ferr", frame_err, 0);
                check("midreset_overrun", overrun, 0);
                reset_n = 1'b1;
            end
        join
        idle(CPB);
        check("abort_no_valid", rx_valid, 0);
        check("abort_no_ferr", ferr_cnt, exp_ferr);
        q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        check("after_reset_data", rx_data, 8'h5A);
        check("after_reset_valid", rx_valid, 1);
        accept();

        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        line = 1'b0;
                        idle($urandom_range(1, HALF - 4));
                        line = 1'b1;
                        idle(CPB);
                    end
                    b   = 8'($urandom);
                    bad = ($urandom_range(0, 4) == 0);
                    if (bad) exp_ferr++;
                    else     q.push_back(b);
                    send_frame(b, !bad);
                    idle($urandom_range(CPB, 3 * CPB));
                end
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk);
                #1 rx_ready = ($urandom_range(0, 3) != 0);
            end
        join
        rx_ready = 1'b1;
        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 1000) begin
            idle(1);
            wait_cnt++;
        end
        rx_ready = 1'b0;
        idle(2);
        check("drain_queue", q.size(), 0);
        check("random_ferr_count", ferr_cnt, exp_ferr);
        check("random_no_overrun", overrun, 0);
        check("random_final_valid", rx_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
